// File: rtl/encoder_velocity.sv
// encoder_velocity: velocity from an offset-binary position count, averaged over 2^AVG_SHIFT sample
// periods, with direction, stall detection and a sticky alias warning.
module encoder_velocity #(
    parameter int CLK_PER_SAMPLE = 50000,
    parameter int AVG_SHIFT      = 2,
    parameter int STALL_WINDOWS  = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] pos,
    output logic [15:0] vel,
    output logic        vel_valid,
    output logic        dir,
    output logic        stalled,
    output logic        ovf
);
    localparam int CW = $clog2(CLK_PER_SAMPLE);
    localparam logic [0:0] PRIME = 1'b0;
    localparam logic [0:0] RUN   = 1'b1;

    logic [CW-1:0]      cnt;
    logic               tick;
    logic [0:0]         state;
    logic [15:0]        pos_prev;
    logic signed [15:0] delta;
    logic signed [19:0] acc;
    logic signed [19:0] sum;
    logic signed [19:0] sum_q;
    logic signed [19:0] avg;
    logic [4:0]         win;
    logic               last;
    logic               pend;
    logic [7:0]         zr;
    logic [7:0]         zr_next;
    logic [15:0]        vel_next;

    always_comb begin
        tick     = cnt == CW'(CLK_PER_SAMPLE - 1);
        delta    = pos - pos_prev;
        sum      = acc + {{4{delta[15]}}, delta};
        last     = win == 5'((1 << AVG_SHIFT) - 1);
        avg      = sum_q >>> AVG_SHIFT;
        vel_next = avg[15:0];
        zr_next  = vel_next != 16'h0 ? 8'd0 : (zr == 8'hFF ? zr : zr + 8'd1);
    end

    // The window sum is latched on its closing tick and published one cycle later.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= '0;
            state     <= PRIME;
            pos_prev  <= 16'h8000;
            acc       <= '0;
            sum_q     <= '0;
            win       <= '0;
            pend      <= 1'b0;
            zr        <= '0;
            vel       <= '0;
            vel_valid <= 1'b0;
            dir       <= 1'b1;
            stalled   <= 1'b0;
            ovf       <= 1'b0;
        end else begin
            cnt       <= tick ? '0 : cnt + 1'b1;
            vel_valid <= pend;
            pend      <= 1'b0;
            if (tick) begin
                pos_prev <= pos;
                if (state == PRIME) begin
                    state <= RUN;
                end else begin
                    if (delta >= 16'sh4000 || delta <= -16'sh4000) ovf <= 1'b1;
                    if (last) begin
                        acc   <= '0;
                        win   <= '0;
                        sum_q <= sum;
                        pend  <= 1'b1;
                    end else begin
                        acc <= sum;
                        win <= win + 1'b1;
                    end
                end
            end
            if (pend) begin
                vel     <= vel_next;
                dir     <= vel_next == 16'h0 ? dir : ~vel_next[15];
                zr      <= zr_next;
                stalled <= zr_next >= 8'(STALL_WINDOWS);
            end
        end
    end
endmodule

// File: tb/tb_encoder_velocity.sv
// tb_encoder_velocity: directed windows with a scoreboard of expected strobes for encoder_velocity.
module tb_encoder_velocity;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] pos = 16'h8000;
    logic [15:0] vel;
    logic        vel_valid;
    logic        dir;
    logic        stalled;
    logic        ovf;

    typedef struct {
        logic [15:0] vel;
        logic        dir;
        logic        st;
        logic        ovf;
        int          at;
    } exp_t;

    exp_t q[$];
    int   passed = 0;
    int   total = 0;
    int   since = 0;

    encoder_velocity #(.CLK_PER_SAMPLE(10), .AVG_SHIFT(2), .STALL_WINDOWS(3)) dut (
        .clk(clk), .rst(rst), .pos(pos), .vel(vel), .vel_valid(vel_valid),
        .dir(dir), .stalled(stalled), .ovf(ovf)
    );

    always #5 clk = ~clk;

    always @(posedge clk) since <= rst ? 0 : since + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    task automatic push(input logic [15:0] v, input logic d, input logic s, input logic o, input int at);
        exp_t e;
        e.vel = v; e.dir = d; e.st = s; e.ovf = o; e.at = at;
        q.push_back(e);
    endtask

    // Junk on pos for half the period proves only the tick-cycle value is used.
    task automatic step(input logic [15:0] p);
        pos = 16'($urandom);
        repeat (5) @(posedge clk);
        #1 pos = p;
        repeat (5) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        repeat (3) @(posedge clk);
        #1 chk("queue_drained", q.size(), 0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_vel", vel, 16'h0000);
        chk("rst_valid", vel_valid, 0);
        chk("rst_dir", dir, 1);
        chk("rst_stalled", stalled, 0);
        chk("rst_ovf", ovf, 0);
        rst = 1'b0;
    endtask

    always @(negedge clk) begin
        if (!rst && vel_valid) begin
            if (q.size() == 0) begin
                chk("unexpected_strobe", vel_valid, 0);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("vel", vel, e.vel);
                chk("dir", dir, e.dir);
                chk("stalled", stalled, e.st);
                chk("ovf", ovf, e.ovf);
                if (e.at != 0) chk("strobe_clk", since, e.at);
            end
        end
    end

    initial begin
        // Held position: zeros, stall on the third zero window.
        do_reset();
        push(16'h0000, 1, 0, 0, 51);
        push(16'h0000, 1, 0, 0, 0);
        push(16'h0000, 1, 1, 0, 0);
        for (int i = 0; i < 13; i++) step(16'h8000);
        // Steady +3 per period.
        do_reset();
        push(16'h0003, 1, 0, 0, 51);
        push(16'h0003, 1, 0, 0, 0);
        for (int i = 0; i < 9; i++) step(16'(16'h8000 + 3 * i));
        // +3 across the 16-bit wrap.
        do_reset();
        push(16'h0003, 1, 0, 0, 51);
        step(16'hFFFA); step(16'hFFFD); step(16'h0000); step(16'h0003); step(16'h0006);
        // Reverse, zero window keeps dir, floor of -7/4, then +7/4.
        push(16'hFFFB, 0, 0, 0, 0);
        step(16'h0001); step(16'hFFFC); step(16'hFFF7); step(16'hFFF2);
        push(16'h0000, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) step(16'hFFF2);
        push(16'hFFFE, 0, 0, 0, 0);
        step(16'hFFF1); step(16'hFFEF); step(16'hFFED); step(16'hFFEB);
        push(16'h0001, 1, 0, 0, 0);
        step(16'hFFEC); step(16'hFFEE); step(16'hFFF0); step(16'hFFF2);
        // Alias threshold: +/-0x3FFF is legal, +0x4000 sets ovf for good.
        do_reset();
        push(16'h0000, 1, 0, 0, 51);
        step(16'h8000); step(16'hBFFF); step(16'h8000); step(16'h8000); step(16'h8000);
        push(16'h1000, 1, 0, 1, 0);
        for (int i = 0; i < 4; i++) step(16'hC000);
        push(16'h0000, 1, 0, 1, 0);
        for (int i = 0; i < 4; i++) step(16'hC000);
        // Reset mid-window discards the partial sum.
        do_reset();
        step(16'h8000); step(16'h8003); step(16'h8006);
        do_reset();
        push(16'h0003, 1, 0, 0, 51);
        for (int i = 0; i < 5; i++) step(16'(16'h8000 + 3 * i));
        repeat (3) @(posedge clk);
        #1 chk("final_queue_drained", q.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
